// File: rtl/tff_bank_ctrl_pkg.sv
// Shared types and mode encodings for the T-flip-flop bank sequencer.
package tff_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CALC   = 2'd1,
    ST_SETTLE = 2'd2,
    ST_CHECK  = 2'd3
  } state_t;

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_UP   = 2'b01;
  localparam logic [1:0] MODE_DOWN = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

endpackage

// File: rtl/tff_bank_ctrl_if.sv
// Command/feedback bundle between the command source, the T bank and the controller.
interface tff_bank_ctrl_if #(
  parameter int W = 4
);
  logic         start;
  logic [1:0]   mode;
  logic         stop;
  logic [W-1:0] load_val;
  logic [W-1:0] q_in;
  logic [W-1:0] t_out;
  logic         busy;
  logic         tc;
  logic         done;
  logic         err;

  modport master (
    output start, mode, stop, load_val, q_in,
    input  t_out, busy, tc, done, err
  );

  modport slave (
    input  start, mode, stop, load_val, q_in,
    output t_out, busy, tc, done, err
  );
endinterface

// File: rtl/tff_next_val.sv
// Modulo-MOD next-value rule for the T bank; the only place the modulus arithmetic lives.
module tff_next_val
  import tff_ctrl_pkg::*;
#(
  parameter int W   = 4,
  parameter int MOD = 10
) (
  input  logic [W-1:0] q,
  input  logic [1:0]   mode,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] nxt,
  output logic         wrap
);

  // The modulus may equal 2^W, so range tests are done one bit wider.
  localparam logic [W:0]   MOD_X = (W+1)'(MOD);
  localparam logic [W-1:0] TOP   = W'(MOD - 1);

  logic q_hi;
  logic lv_hi;

  assign q_hi  = ({1'b0, q} >= MOD_X);
  assign lv_hi = ({1'b0, load_val} >= MOD_X);

  always_comb begin
    nxt  = q;
    wrap = 1'b0;
    case (mode)
      MODE_UP: begin
        wrap = (q == TOP);
        nxt  = (q >= TOP) ? '0 : q + W'(1);
      end
      MODE_DOWN: begin
        wrap = (q == '0);
        nxt  = ((q == '0) || q_hi) ? TOP : q - W'(1);
      end
      MODE_LOAD: begin
        nxt = lv_hi ? '0 : load_val;
      end
      default: begin
        nxt  = q;
        wrap = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/tff_bank_ctrl.sv
// Turns up/down/load commands into one-cycle toggle enables for a bank of T cells,
// then verifies the bank landed on the expected value.
module tff_bank_ctrl
  import tff_ctrl_pkg::*;
#(
  parameter int W   = 4,
  parameter int MOD = 10
) (
  input logic            clk,
  input logic            rst,
  tff_bank_ctrl_if.slave bus
);

  state_t       state;
  logic [1:0]   mode_l;
  logic [W-1:0] load_l;
  logic [W-1:0] exp_v;
  logic         stop_f;
  logic [W-1:0] nxt;
  logic         wrap;

  logic [W-1:0] t_out_r;
  logic         busy_r;
  logic         tc_r;
  logic         done_r;
  logic         err_r;

  tff_next_val #(
    .W   (W),
    .MOD (MOD)
  ) u_next_val (
    .q        (bus.q_in),
    .mode     (mode_l),
    .load_val (load_l),
    .nxt      (nxt),
    .wrap     (wrap)
  );

  // Data captures carry no reset: exp_v is only read in CHECK after a CALC wrote it.
  always_ff @(posedge clk) begin
    if (state == ST_IDLE && bus.start) begin
      load_l <= bus.load_val;
    end
    if (state == ST_CALC) begin
      exp_v <= nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      mode_l  <= MODE_HOLD;
      stop_f  <= 1'b0;
      t_out_r <= '0;
      busy_r  <= 1'b0;
      tc_r    <= 1'b0;
      done_r  <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      done_r <= 1'b0;
      tc_r   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            mode_l <= bus.mode;
            stop_f <= 1'b0;
            if (bus.mode == MODE_HOLD) begin
              done_r <= 1'b1;
            end else begin
              state  <= ST_CALC;
              busy_r <= 1'b1;
            end
          end
        end
        ST_CALC: begin
          t_out_r <= bus.q_in ^ nxt;
          tc_r    <= wrap;
          state   <= ST_SETTLE;
          if (bus.stop) stop_f <= 1'b1;
        end
        ST_SETTLE: begin
          // The bank toggles on this edge; enables drop at the same time.
          t_out_r <= '0;
          state   <= ST_CHECK;
          if (bus.stop) stop_f <= 1'b1;
        end
        ST_CHECK: begin
          if (bus.q_in != exp_v) err_r <= 1'b1;
          if (mode_l == MODE_LOAD || stop_f) begin
            done_r <= 1'b1;
            busy_r <= 1'b0;
            state  <= ST_IDLE;
          end else begin
            stop_f <= 1'b0;
            state  <= ST_CALC;
          end
        end
        default: begin
          state  <= ST_IDLE;
          busy_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.t_out = t_out_r;
  assign bus.busy  = busy_r;
  assign bus.tc    = tc_r;
  assign bus.done  = done_r;
  assign bus.err   = err_r;

endmodule

// File: tb/tb_tff_bank_ctrl.sv
// Closed-loop bench: controller driving W T cells, checked against a modulo-arithmetic model.
module tb_tff_bank_ctrl;
  import tff_ctrl_pkg::*;

  localparam int W   = 4;
  localparam int MOD = 10;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  tff_bank_ctrl_if #(.W(W)) bus ();

  tff_bank_ctrl #(.W(W), .MOD(MOD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // T bank: each cell toggles when its tin is high unless the bench holds it stuck.
  logic [W-1:0] bq;
  logic [W-1:0] stuck;
  logic [W-1:0] pre_v;
  logic         pre_en;

  for (genvar i = 0; i < W; i++) begin : g_cell
    logic q;
    always @(posedge clk) begin
      if (pre_en)                            q <= pre_v[i];
      else if (bus.t_out[i] && !stuck[i])    q <= ~q;
    end
    assign bq[i] = q;
  end
  assign bus.q_in = bq;

  int n_chk  = 0;
  int n_fail = 0;
  int mv     = 0;
  int err_exp = 0;

  task automatic chk(input string tag, input int got, input int want);
    n_chk++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, want);
    end
  endtask

  function automatic int m_nxt(input int m, input int q, input int lv);
    case (m)
      1: return (q < MOD) ? (q + 1) % MOD : 0;
      2: return (q < MOD) ? (q + MOD - 1) % MOD : MOD - 1;
      3: return (lv < MOD) ? lv : 0;
      default: return q;
    endcase
  endfunction

  function automatic int m_wrap(input int m, input int q);
    return ((m == 1 && q == MOD - 1) || (m == 2 && q == 0)) ? 1 : 0;
  endfunction

  task automatic preset(input int v);
    @(negedge clk);
    pre_en = 1'b1;
    pre_v  = W'(v);
    @(negedge clk);
    pre_en = 1'b0;
    mv     = v;
  endtask

  // One command: start accepted at the next edge, then 3 cycles per step, done one cycle after the last CHECK.
  task automatic run_cmd(input int m, input int lv, input int n, input int stop_ph,
                         input bit spam, input int fstep, input int fmask);
    int steps;
    int last;
    int stop_c;
    int tog;
    int expv;
    steps  = (m == 3) ? 1 : n;
    last   = 3 * steps + 1;
    stop_c = 1 + 3 * (steps - 1) + stop_ph;
    tog    = 0;
    expv   = 0;
    @(negedge clk);
    bus.start    = 1'b1;
    bus.mode     = 2'(m);
    bus.load_val = W'(lv);
    for (int c = 1; c <= last; c++) begin
      int k;
      int ph;
      k  = (c - 1) / 3;
      ph = (c - 1) % 3;
      @(negedge clk);
      chk($sformatf("err c%0d", c), int'(bus.err), err_exp);
      if (c == last) begin
        chk("done_pulse", int'(bus.done), 1);
        chk("busy_end", int'(bus.busy), 0);
        chk("t_out_end", int'(bus.t_out), 0);
        chk("tc_end", int'(bus.tc), 0);
      end else begin
        chk($sformatf("busy c%0d", c), int'(bus.busy), 1);
        chk($sformatf("done c%0d", c), int'(bus.done), 0);
        if (ph == 1) begin
          expv = m_nxt(m, mv, lv);
          tog  = mv ^ expv;
          chk($sformatf("t_out step%0d", k), int'(bus.t_out), tog);
          chk($sformatf("tc step%0d", k), int'(bus.tc), m_wrap(m, mv));
          stuck = (k == fstep) ? W'(fmask) : '0;
          mv = mv ^ (tog & ~((k == fstep) ? fmask : 0));
        end else begin
          chk($sformatf("t_out idle c%0d", c), int'(bus.t_out), 0);
          chk($sformatf("tc idle c%0d", c), int'(bus.tc), 0);
        end
        if (ph == 2) begin
          chk($sformatf("bank step%0d", k), int'(bq), mv);
          stuck = '0;
          if (mv != expv) err_exp = 1;
        end
      end
      // Noise while busy: extra starts anywhere, stops only in CHECK where they are not captured.
      if (spam && c < last) begin
        bus.start    = 1'($urandom_range(0, 1));
        bus.mode     = 2'($urandom_range(0, 3));
        bus.load_val = W'($urandom_range(0, 15));
      end else begin
        bus.start = 1'b0;
      end
      if (c == stop_c)                      bus.stop = 1'b1;
      else if (spam && ph == 2 && c < last) bus.stop = 1'($urandom_range(0, 1));
      else                                  bus.stop = 1'b0;
    end
    @(negedge clk);
    bus.stop = 1'b0;
    chk("done_after", int'(bus.done), 0);
    chk("busy_after", int'(bus.busy), 0);
  endtask

  initial begin
    bus.start    = 1'b0;
    bus.mode     = 2'b00;
    bus.stop     = 1'b0;
    bus.load_val = '0;
    stuck        = '0;
    rst          = 1'b1;
    pre_en       = 1'b1;
    pre_v        = 4'd5;
    repeat (2) @(negedge clk);
    pre_en = 1'b0;
    mv     = 5;
    @(negedge clk);
    chk("rst t_out", int'(bus.t_out), 0);
    chk("rst busy", int'(bus.busy), 0);
    chk("rst tc", int'(bus.tc), 0);
    chk("rst done", int'(bus.done), 0);
    chk("rst err", int'(bus.err), 0);
    chk("rst bank", int'(bq), 5);
    rst = 1'b0;

    preset(7);
    run_cmd(1, 0, 4, 0, 1'b0, -1, 0);
    chk("up final", int'(bq), 1);

    preset(1);
    run_cmd(2, 0, 3, 1, 1'b0, -1, 0);
    chk("down final", int'(bq), 8);

    preset(3);
    run_cmd(3, 12, 1, 0, 1'b0, -1, 0);
    chk("load12 final", int'(bq), 0);
    preset(3);
    run_cmd(3, 6, 1, 0, 1'b0, -1, 0);
    chk("load6 final", int'(bq), 6);

    @(negedge clk);
    bus.start = 1'b1;
    bus.mode  = MODE_HOLD;
    @(negedge clk);
    bus.start = 1'b0;
    chk("hold done", int'(bus.done), 1);
    chk("hold busy", int'(bus.busy), 0);
    @(negedge clk);
    chk("hold done off", int'(bus.done), 0);
    chk("hold bank", int'(bq), mv);

    preset(4);
    run_cmd(1, 0, 2, 1, 1'b0, -1, 0);
    run_cmd(2, 0, 3, 0, 1'b1, -1, 0);

    preset(2);
    run_cmd(1, 0, 3, 0, 1'b0, 0, 1);
    run_cmd(1, 0, 1, 0, 1'b1, -1, 0);
    chk("err sticky", int'(bus.err), 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    err_exp = 0;
    chk("err cleared", int'(bus.err), 0);

    preset(4);
    @(negedge clk);
    bus.start = 1'b1;
    bus.mode  = MODE_UP;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    chk("pre-rst t_out", int'(bus.t_out), 1);
    rst = 1'b1;
    @(negedge clk);
    chk("rst-settle t_out", int'(bus.t_out), 0);
    chk("rst-settle busy", int'(bus.busy), 0);
    chk("rst-settle bank", int'(bq), 5);
    rst = 1'b0;
    mv  = 5;

    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 2) == 0) preset(int'($urandom_range(0, MOD - 1)));
      run_cmd(int'($urandom_range(1, 3)), int'($urandom_range(0, 15)),
              int'($urandom_range(1, 5)), int'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), -1, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
